// File: rtl/da_pkg.sv
// Shared constants and types for the distributed-arithmetic FIR output path.
package da_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int DA_RESULT_DEPTH = 8;

  typedef logic signed [WORD_WIDTH-1:0] da_sample_t;

endpackage : da_pkg

// File: rtl/da_result_mem.sv
// DEPTH x WORD_WIDTH register array: one write port, one registered read port
// with write-through so a word written to the address being read appears next cycle.
module da_result_mem #(
  parameter int WORD_WIDTH = da_pkg::WORD_WIDTH,
  parameter int DEPTH      = da_pkg::DA_RESULT_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  // NOTE: storage has no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : da_result_mem

// File: rtl/da_result_fifo.sv
// Show-ahead capture FIFO behind the DA FIR: one push per rising edge of in_ts,
// valid/ready output, sticky overflow. DA_RESULT_DROPCNT_EN adds a saturating drop_cnt.
module da_result_fifo #(
  parameter int WORD_WIDTH = da_pkg::WORD_WIDTH,
  parameter int DEPTH      = da_pkg::DA_RESULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_ts,
  input  logic [WORD_WIDTH-1:0]      in_y,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WORD_WIDTH-1:0]      m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
`ifdef DA_RESULT_DROPCNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic          ts_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push_req, push, pop, drop, full, rd_en;

  assign m_valid  = (level_q != '0);
  assign full     = (level_q == FULL_LEVEL);
  assign push_req = in_ts & ~ts_q & ~flush;
  assign pop      = m_valid & m_ready & ~flush;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // NOTE: every always_comb output starts from its hold value so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  // Read register tracks the next head; it holds while the FIFO is going empty.
  assign rd_en = (level_d != '0);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= in_ts;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

`ifdef DA_RESULT_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  da_result_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_y),
    .re    (rd_en),
    .raddr (rd_ptr_d),
    .rdata (m_data)
  );

endmodule : da_result_fifo

// File: tb/tb_da_result_fifo.sv
// Directed self-checking bench for da_result_fifo (DEPTH=8, WORD_WIDTH=16).
module tb_da_result_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_ts;
  logic [W-1:0]  in_y;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [3:0]    level;
  logic          overflow;
`ifdef DA_RESULT_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  da_result_fifo #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_ts    (in_ts),
    .in_y     (in_y),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .overflow (overflow)
`ifdef DA_RESULT_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe edge with value v, then strobe low for a cycle.
  task automatic strobe(input logic [W-1:0] v);
    in_ts = 1'b1;
    in_y  = v;
    tick();
    in_ts = 1'b0;
    tick();
  endtask

  initial begin
    logic [W-1:0] exp_q [8];
    da_pkg::da_sample_t sval;

    rst = 1'b0; flush = 1'b0; in_ts = 1'b0; in_y = '0; m_ready = 1'b0;
    #2;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);

    // Single pulse captured in first cycle after release, then consumed.
    tick();
    rst = 1'b1; in_ts = 1'b1; in_y = 16'h1234; m_ready = 1'b1;
    tick();
    in_ts = 1'b0;
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_data", 32'(m_data), 32'h1234);
    check("t1_level", 32'(level), 32'd1);
    tick();
    check("t1_drained", 32'(level), 32'd0);
    check("t1_empty", 32'(m_valid), 32'd0);

    // Strobe held high 4 cycles: one entry of the first value.
    m_ready = 1'b0;
    in_ts = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_y = W'(i);
      tick();
    end
    in_ts = 1'b0;
    tick();
    check("t2_level", 32'(level), 32'd1);
    check("t2_data", 32'(m_data), 32'h0001);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t2_drained", 32'(level), 32'd0);

    // Nine edges into eight entries: value 9 dropped.
    for (int i = 1; i <= 9; i++) strobe(W'(i));
    check("t3_level", 32'(level), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head", 32'(m_data), 32'h0001);
`ifdef DA_RESULT_DROPCNT_EN
    check("t3_dropcnt", 32'(drop_cnt), 32'd1);
`endif
    tick();
    check("t3_stall_data", 32'(m_data), 32'h0001);
    check("t3_stall_valid", 32'(m_valid), 32'd1);

    // Full with simultaneous pop: push accepted, level stays 8.
    in_ts = 1'b1; in_y = 16'hAAAA; m_ready = 1'b1;
    tick();
    in_ts = 1'b0;
    check("t4_level", 32'(level), 32'd8);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0006, 16'h0007, 16'h0008, 16'hAAAA};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_drain%0d", k), 32'(m_data), 32'(exp_q[k]));
      tick();
    end
    check("t4_empty", 32'(m_valid), 32'd0);
    check("t4_ovf_after", 32'(overflow), 32'd1);
    m_ready = 1'b0;

    // Flush at level 5 with overflow set and a coincident strobe edge.
    for (int i = 0; i < 5; i++) strobe(W'(16'h0010 + i));
    check("t5_level", 32'(level), 32'd5);
    flush = 1'b1; in_ts = 1'b1; in_y = 16'hBEEF;
    tick();
    flush = 1'b0;
    check("t5_level0", 32'(level), 32'd0);
    check("t5_valid0", 32'(m_valid), 32'd0);
    check("t5_ovf0", 32'(overflow), 32'd0);
`ifdef DA_RESULT_DROPCNT_EN
    check("t5_dropcnt0", 32'(drop_cnt), 32'd0);
`endif
    tick();
    check("t5_no_recapture", 32'(level), 32'd0);
    in_ts = 1'b0;
    tick();

    // Push and pop together at level 1: new head appears next cycle.
    strobe(16'h0101);
    in_ts = 1'b1; in_y = 16'h0202; m_ready = 1'b1;
    tick();
    in_ts = 1'b0;
    check("t6_level", 32'(level), 32'd1);
    check("t6_data", 32'(m_data), 32'h0202);
    tick();
    m_ready = 1'b0;
    check("t6_drained", 32'(level), 32'd0);

    // Asynchronous reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) strobe(W'(16'h0030 + i));
    check("t7_level3", 32'(level), 32'd3);
    #2;
    rst = 1'b0; in_ts = 1'b1; in_y = 16'h7777;
    #1;
    check("t7_arst_valid", 32'(m_valid), 32'd0);
    check("t7_arst_level", 32'(level), 32'd0);
    check("t7_arst_data", 32'(m_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    in_ts = 1'b0;
    sval = da_pkg::da_sample_t'(m_data);
    check("t7_capture_after_rst", 32'(sval), 32'h0000_7777);
    check("t7_level1", 32'(level), 32'd1);
    tick();

    // 7 more fill the FIFO, 300 further edges are all dropped.
    for (int i = 0; i < 307; i++) strobe(W'(i));
    check("t8_level", 32'(level), 32'd8);
    check("t8_ovf", 32'(overflow), 32'd1);
    check("t8_head", 32'(m_data), 32'h7777);
`ifdef DA_RESULT_DROPCNT_EN
    check("t8_dropcnt_sat", 32'(drop_cnt), 32'd255);
`endif

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t8_flush_level", 32'(level), 32'd0);
    check("t8_flush_ovf", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_da_result_fifo
